// File: rtl/ps2_scan_rx_if.sv
// PS/2 receiver bus: the raw device lines in, and the decoded scan-code stream out.
interface ps2_scan_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       ready;
    logic       brk;
    logic       ext;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  code, ready, brk, ext, parity_err, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output code, ready, brk, ext, parity_err, frame_err
    );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit frames and
// folds E0/F0 prefix bytes into ext/brk flags on the following scan code.
module ps2_scan_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_scan_rx_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, RECV} state_t;

    logic          clk_s1_q, clk_s2_q, clk_hist_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;
    state_t        state_q;
    logic [3:0]    bit_cnt_q;
    logic [TW-1:0] timer_q;
    logic [9:0]    shift_q, shift_d;
    logic          pend_brk_q, pend_ext_q;
    logic [7:0]    code_q;
    logic          brk_q, ext_q, ready_q, perr_q, ferr_q;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    // Synchroniser stage: idle PS/2 lines are high, so the flops preset to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= bus.ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_hist_q <= clk_s2_q;
            dat_s1_q   <= bus.ps2_data;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall    = clk_hist_q & ~clk_s2_q;
    assign shift_d = {dat_s2_q, shift_q[9:1]};

    always_ff @(posedge clk) begin
        if (state_q == RECV && fall) begin
            shift_q <= shift_d;
        end
    end

    // Deframing stage: frame evaluation happens in the fall cycle of the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            timer_q    <= '0;
            pend_brk_q <= 1'b0;
            pend_ext_q <= 1'b0;
            code_q     <= 8'h00;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            ready_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (fall && !dat_s2_q) begin
                        state_q   <= RECV;
                        bit_cnt_q <= 4'd1;
                    end
                end
                RECV: begin
                    if (fall) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        timer_q   <= '0;
                        if (bit_cnt_q == 4'd10) begin
                            state_q <= IDLE;
                            if (!parity_ok(shift_d[8:0])) begin
                                perr_q     <= 1'b1;
                                pend_brk_q <= 1'b0;
                                pend_ext_q <= 1'b0;
                            end else if (!shift_d[9]) begin
                                ferr_q     <= 1'b1;
                                pend_brk_q <= 1'b0;
                                pend_ext_q <= 1'b0;
                            end else if (shift_d[7:0] == 8'hF0) begin
                                pend_brk_q <= 1'b1;
                            end else if (shift_d[7:0] == 8'hE0) begin
                                pend_ext_q <= 1'b1;
                            end else begin
                                code_q     <= shift_d[7:0];
                                brk_q      <= pend_brk_q;
                                ext_q      <= pend_ext_q;
                                ready_q    <= 1'b1;
                                pend_brk_q <= 1'b0;
                                pend_ext_q <= 1'b0;
                            end
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        state_q    <= IDLE;
                        timer_q    <= '0;
                        ferr_q     <= 1'b1;
                        pend_brk_q <= 1'b0;
                        pend_ext_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.code       = code_q;
    assign bus.ready      = ready_q;
    assign bus.brk        = brk_q;
    assign bus.ext        = ext_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
PS/2 keyboard receiver that produces the scan-code stream consumed by the two-digit hex display (8-bit code plus a one-cycle ready strobe).
- Synchronises the asynchronous ps2_clk and ps2_data lines and deframes 11-bit device-to-host frames.
- Checks start, odd parity and stop bits.
- Folds the E0 (extended) and F0 (break) prefix bytes into flags on the following code byte.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles with no ps2_clk falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock line from the device; asynchronous.
ps2_data  input  1  raw PS/2 data line from the device; asynchronous.
code  output  8  last accepted non-prefix scan code; held until the next accepted code.
ready  output  1  one-cycle pulse; code/brk/ext are valid in that cycle.
brk  output  1  an F0 prefix preceded this code; held with code.
ext  output  1  an E0 prefix preceded this code; held with code.
parity_err  output  1  one-cycle pulse: frame had a bad parity bit.
frame_err  output  1  one-cycle pulse: bad stop bit, or timeout mid-frame.

Behaviour:
- Synchronisation:
  - Two flops on each of ps2_clk and ps2_data, then one history flop on the synced clock.
  - A falling edge is history=1 and synced=0, giving a one-cycle fall strobe.
  - Data is sampled from the synced ps2_data in the fall cycle.
- States: IDLE, RECV.
- IDLE:
  - On fall with data=0 (start bit): go to RECV with bit_cnt=1 and clear the timer.
  - On fall with data=1: ignore it and stay in IDLE (glitch rejection).
- RECV:
  - Each fall shifts data into a 10-bit shift register, LSB first: 8 data bits, then parity, then stop.
  - Each fall increments bit_cnt and clears the timer.
  - On the fall that brings bit_cnt to 11, evaluate the frame and return to IDLE.
- Frame evaluation (the fall cycle) and outputs (the following cycle):
  - Parity fails when XOR of the data bits and the parity bit is 0 (odd parity required). Result: parity_err pulse; both prefix flags cleared; code unchanged.
  - Else, stop bit = 0. Result: frame_err pulse; both prefix flags cleared.
  - Else, byte = F0. Result: set pend_brk; no ready pulse.
  - Else, byte = E0. Result: set pend_ext; no ready pulse.
  - Else (any other byte). Result: code = byte, brk = pend_brk, ext = pend_ext, ready pulse, then both pending flags cleared.
  - Parity error takes priority over stop error; only one error pulse is raised per frame.
- Latency:
  - ready, parity_err and frame_err assert exactly 1 clk after the fall cycle of the stop bit.
  - Each is high for exactly 1 cycle.
  - Total latency from the raw ps2_clk fall is 3–4 clk.
- Timeout:
  - In RECV the timer increments every cycle without a fall.
  - When the timer reaches TIMEOUT_CYCLES-1, go to IDLE, pulse frame_err next cycle and clear the pending flags.
  - If a fall and the timeout occur in the same cycle, the fall wins and the timer is cleared.
  - The timer is held at 0 in IDLE.
- Pending prefixes persist across idle gaps of any length and are consumed only by a code byte or an error.
- Reset:
  - code=00, brk=0, ext=0, ready=0, parity_err=0, frame_err=0.
  - State=IDLE, bit_cnt=0, timer=0, pending flags=0; synchroniser flops preset to 1 (idle line).
  - Reset asserted mid-frame discards the partial frame; no pulse is emitted.
- Width rules: bit_cnt is 4 bits; timer is $clog2(TIMEOUT_CYCLES) bits wide.

Test Plan:
- Reset, then a 1C frame (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) at 10 kHz PS/2 clock -> one ready pulse, code=1C, brk=0, ext=0, no error pulses; outputs hold afterwards.
- F0 frame then 1C frame -> no ready after F0; a single ready with code=1C, brk=1, ext=0.
- E0, F0, 75 frames -> single ready with code=75, ext=1, brk=1; a following 75 frame gives ext=0, brk=0.
- 1C frame with parity bit flipped to 1 -> parity_err pulse for 1 cycle, no ready, code keeps its previous value.
- 1C frame with stop bit 0 -> frame_err pulse, no ready.
- Start bit 1 (glitch) -> no state change, no pulse; a subsequent valid frame is received normally.
- Five bits of a frame, then the line held high, with TIMEOUT_CYCLES=100 -> frame_err pulse about 100 cycles after the last fall; a following valid 1C frame is received correctly.
- rst pulsed after 6 bits, then a full 1C frame -> no pulse at reset; 1C is received cleanly.
